// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;

  localparam logic [3:0] BE_ALL     = 4'hF;
  localparam int         BYTE_LANES = 4;
endpackage

// File: rtl/dmem_watchdog.sv
// Cycle counter for the BUSY phase; expired marks the last cycle an ack may still arrive.
module dmem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int              CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // High in the TIMEOUT-th enabled cycle, so the request is held exactly TIMEOUT cycles.
  assign expired = enable && (r_count == LAST);
endmodule

// File: rtl/dmem_ctrl.sv
// Stalls the core for one request/ack memory transaction and returns registered load data.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [BYTE_LANES-1:0] wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  stall,
  output logic                  fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [BYTE_LANES-1:0] mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  dmem_state_t           r_state;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_fault;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [BYTE_LANES-1:0] r_mem_be;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic w_req;
  logic w_store;
  logic w_illegal;
  logic w_busy;
  logic w_expired;
  logic w_unused;

  assign w_store   = |wr_en;
  assign w_req     = rd_en | w_store;
  assign w_illegal = rd_en & w_store;
  assign w_busy    = (r_state == BUSY);
  assign w_unused  = ^addr[1:0];

  dmem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (~w_busy | mem_ack),
    .enable  (w_busy),
    .expired (w_expired)
  );

  // Only the IDLE sample cycle looks at the core pins combinationally.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      IDLE:    stall = w_req;
      BUSY:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rd_data   <= '0;
      r_fault     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            // A simultaneous load and store resolves to the store and is flagged.
            r_state     <= BUSY;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_store;
            r_mem_be    <= w_store ? wr_en : BE_ALL;
            r_mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            r_mem_wdata <= wr_data;
            r_fault     <= w_illegal;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            if (!r_mem_we) r_rd_data <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else if (w_expired) begin
            r_rd_data <= '0;
            r_fault   <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rd_data   = r_rd_data;
  assign fault     = r_fault;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Transaction-level reference for dmem_ctrl: expected outputs per cycle come from the request shape and ack delay.
module tb_dmem_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_en;
  logic [3:0]  wr_en;
  logic [31:0] addr, wr_data, rd_data;
  logic        stall, fault, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .stall(stall), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, stall_cnt = 0, req_cnt = 0, fault_cnt = 0;
  int req_rise_cyc = 0, req_fall_cyc = 0;
  logic prev_req = 1'b0;

  // Expected values for the current cycle, written by the driver.
  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_fault, e_mem, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_rd, e_addr, e_wdata;
  logic [31:0] m_rd;

  // One-shot literal expectation, evaluated by the compare process.
  logic        p_on = 1'b0;
  string       p_nm;
  logic [31:0] p_act, p_exp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (stall) stall_cnt = stall_cnt + 1;
    if (mem_req) req_cnt = req_cnt + 1;
    if (fault) fault_cnt = fault_cnt + 1;
    if (mem_req && !prev_req) req_rise_cyc = cyc;
    if (!mem_req && prev_req) req_fall_cyc = cyc;
    prev_req = mem_req;
    if (p_on) chk(p_nm, p_act, p_exp);
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      chk("fault", {31'd0, fault}, {31'd0, e_fault});
      chk("rd_data", rd_data, e_rd);
      if (e_mem) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rd_en = 1'b0; wr_en = 4'h0; mem_ack = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_mem = 1'b0; e_rd = m_rd;
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    set_idle();
    p_nm = nm; p_act = act; p_exp = exp; p_on = 1'b1;
    tick();
    p_on = 1'b0;
  endtask

  // ack_after = BUSY cycles before the ack cycle; ack_after >= TO means no ack at all.
  task automatic txn(input logic rd, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rdat,
                     input int ack_after, input int gap);
    logic st, acked;
    int   busy_len;
    st       = (be != 4'h0);
    acked    = (ack_after < TO);
    busy_len = acked ? ack_after + 1 : TO;
    rd_en = rd; wr_en = be; addr = a; wr_data = wd; mem_ack = 1'b0; mem_rdata = $urandom;
    e_stall = 1'b1; e_req = 1'b0; e_fault = 1'b0; e_mem = 1'b0; e_rd = m_rd;
    tick();
    for (int k = 1; k <= busy_len; k++) begin
      e_req = 1'b1; e_stall = 1'b1; e_mem = 1'b1;
      e_fault = (k == 1) && rd && st;
      e_we = st; e_be = st ? be : 4'hF; e_addr = {a[31:2], 2'b00}; e_wdata = wd;
      mem_ack = acked && (k == busy_len);
      mem_rdata = mem_ack ? rdat : $urandom;
      tick();
    end
    if (!acked) m_rd = 32'h0;
    else if (!st) m_rd = rdat;
    // DONE: core pins still carry the request, and a stray ack must be ignored.
    e_req = 1'b0; e_stall = 1'b0; e_mem = 1'b0; e_fault = !acked; e_rd = m_rd;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    tick();
    for (int g = 0; g < gap; g++) begin
      set_idle();
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      tick();
    end
  endtask

  int s0, r0, f0, fall0;

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 4'h0; addr = 32'h0; wr_data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0; m_rd = 32'h0;
    tick();
    // Reset state, still under reset.
    chk_en = 1'b1;
    e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_rd = 32'h0;
    e_mem = 1'b1; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    tick();
    reset = 1'b0;
    set_idle();
    tick();

    // Load with ack in the second BUSY cycle.
    s0 = stall_cnt;
    txn(1'b1, 4'h0, 32'h0000_1006, 32'h0, 32'hDEAD_BEEF, 1, 1);
    pin("load_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    pin("load_rd_data", rd_data, 32'hDEAD_BEEF);
    pin("load_mem_addr", mem_addr, 32'h0000_1004);
    pin("load_mem_be", {28'd0, mem_be}, 32'hF);

    // Store with immediate ack.
    s0 = stall_cnt;
    txn(1'b0, 4'b1100, 32'h0000_2002, 32'hAB00_0000, 32'h1111_2222, 0, 1);
    pin("store_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    pin("store_rd_unchanged", rd_data, 32'hDEAD_BEEF);
    pin("store_mem_we", {31'd0, mem_we}, 32'd1);
    pin("store_mem_be", {28'd0, mem_be}, 32'hC);

    // Timeout on a load.
    r0 = req_cnt; f0 = fault_cnt;
    txn(1'b1, 4'h0, 32'h0000_3000, 32'h0, 32'h0, TO + 3, 1);
    pin("timeout_req_cycles", 32'(req_cnt - r0), 32'd4);
    pin("timeout_fault_pulses", 32'(fault_cnt - f0), 32'd1);
    pin("timeout_rd_zero", rd_data, 32'h0);

    // Illegal load+store executes as a store.
    f0 = fault_cnt;
    txn(1'b1, 4'hF, 32'h0000_4008, 32'h1234_5678, 32'h0, 0, 1);
    pin("illegal_fault_pulses", 32'(fault_cnt - f0), 32'd1);
    pin("illegal_mem_we", {31'd0, mem_we}, 32'd1);

    // Ack arriving in the very last allowed cycle wins over the watchdog.
    r0 = req_cnt; f0 = fault_cnt;
    txn(1'b1, 4'h0, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, TO - 1, 1);
    pin("late_ack_no_fault", 32'(fault_cnt - f0), 32'd0);
    pin("late_ack_rd_data", rd_data, 32'hCAFE_F00D);

    // Back-to-back store then load.
    r0 = req_cnt;
    txn(1'b0, 4'b0011, 32'h0000_6000, 32'h0000_BEAD, 32'h0, 0, 0);
    fall0 = req_fall_cyc;
    txn(1'b1, 4'h0, 32'h0000_6004, 32'h0, 32'h7777_8888, 0, 1);
    pin("b2b_req_gap", 32'(req_rise_cyc - fall0), 32'd2);
    pin("b2b_req_cycles", 32'(req_cnt - r0), 32'd2);

    // Reset while BUSY, then an ack one cycle after reset.
    rd_en = 1'b1; wr_en = 4'h0; addr = 32'h0000_7003; wr_data = 32'h0;
    e_stall = 1'b1; e_req = 1'b0; e_mem = 1'b0; e_fault = 1'b0; e_rd = m_rd;
    tick();
    e_req = 1'b1; e_mem = 1'b1; e_we = 1'b0; e_be = 4'hF; e_addr = 32'h0000_7000; e_wdata = 32'h0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; rd_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    m_rd = 32'h0;
    e_stall = 1'b0; e_req = 1'b0; e_fault = 1'b0; e_rd = 32'h0;
    e_mem = 1'b1; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    tick();
    set_idle();
    tick();
    pin("post_reset_rd_data", rd_data, 32'h0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic       r;
      logic [3:0] b;
      r = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if (!r && b == 4'h0) r = 1'b1;
      txn(r, b, $urandom, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom_range(0, 2));
    end
    set_idle();
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
